counter_seq_checker: RTL and testbench
======================================

Name: counter_seq_checker

Overview:
- Passive monitor on the bounded 10..40 up/down counter interface.
- Samples the counter's control inputs (ctr_rst_n, load, u_d, data) and its count output each clock, and predicts the next count.
- Flags mismatches, counts up/down wrap events and out-of-range recoveries, and halts after a configurable number of errors.
- Sits beside the counter in the testbench and in the debug fabric; it never drives the counter.

Parameters:
- WIDTH, 8, width of the count and data buses
- MIN, 10, lower bound of the legal count range
- MAX, 40, upper bound of the legal count range
- ERR_LIMIT, 4, number of mismatches that moves the checker to HALT (1..255)

Ports:
- clk  input  1  rising-edge clock, shared with the monitored counter
- rst  input  1  asynchronous active-low reset of the checker
- en  input  1  enable monitoring; 0 returns the checker to IDLE
- clr  input  1  synchronous clear of state and statistics; priority over en
- ctr_rst_n  input  1  monitored counter's synchronous active-low reset
- load  input  1  monitored counter's load
- u_d  input  1  monitored counter's direction (1 = up)
- data  input  WIDTH  monitored counter's load data
- count_in  input  WIDTH  monitored counter's count output
- exp_count  output  WIDTH  registered predicted value for count_in in the current cycle
- err  output  1  one-cycle pulse on mismatch
- err_cnt  output  8  saturating mismatch count
- wrap_up_cnt  output  8  saturating count of MAX->MIN wraps verified
- wrap_dn_cnt  output  8  saturating count of MIN->MAX wraps verified
- oor  output  1  one-cycle pulse when a verified step was an out-of-range forced-to-0 step
- halted  output  1  high in HALT

Behaviour:
- Reset (rst=0, asynchronous) puts the checker in IDLE and clears every output and internal register to 0.
- Predictor f(c) is combinational from this cycle's sampled inputs, with c = count_in. Priority order:
  - ctr_rst_n=0, or c>MAX, or c<MIN: result 0, kind = OOR (reported via oor only when ctr_rst_n=1).
  - load=1: result data.
  - u_d=1: if c>=MAX, result MIN (kind = WRAP_UP); else c+1.
  - u_d=0: if c<=MIN, result MAX (kind = WRAP_DN); else c-1.
  - All arithmetic is WIDTH bits.
- Each posedge when the next state is TRACK:
  - exp_count <= f(count_in).
  - The kind tag is registered alongside exp_count.
- States:
  - IDLE: no comparison. If en=1 and clr=0, load the prediction and go to TRACK.
  - TRACK: compare count_in with exp_count.
    - Match: if the registered kind is WRAP_UP, increment wrap_up_cnt; if WRAP_DN, increment wrap_dn_cnt; if OOR, pulse oor.
    - Mismatch: pulse err and increment err_cnt. If the new err_cnt equals ERR_LIMIT, go to HALT; otherwise stay in TRACK and reload the prediction from the actual count_in (resynchronise).
    - en=0: go to IDLE. The comparison of that cycle is still made.
  - HALT: halted=1. Prediction, comparison and all counters are frozen. Only clr or rst exit, to IDLE.
- Comparison timing: the comparison result is registered, so err and oor rise one clock after the offending count_in sample and last exactly 1 cycle.
- clr=1 in any state:
  - Next state IDLE.
  - err_cnt, wrap counters, exp_count and the kind tag all go to 0.
  - err and oor are forced low in that cycle.
- Counters saturate at 255 and never wrap.
- Simultaneous events:
  - A mismatch on a predicted wrap counts as an error only, not a wrap.
  - err and oor are never high together.
- Reset mid-operation: rst asserted while in TRACK or HALT clears everything asynchronously. Monitoring resumes only through IDLE, with one cycle of no comparison.
- Latency:
  - First comparison: the second posedge after en rises in IDLE.
  - Flag output: one posedge after that.

Test Plan:
- Up run: en=1, u_d=1, count 38,39,40,10,11 → err never pulses; wrap_up_cnt=1; exp_count tracks 39,40,10,11.
- Down wrap: count 11,10,40 with u_d=0 → wrap_dn_cnt=1, err=0.
- Load: load=1 with data=25 at count=30, then count_in=25 → no error. Inject count_in=26 instead → err pulses once and err_cnt=1; prediction resyncs and the following correct steps are clean.
- Out of range: count_in=50 with ctr_rst_n=1, next count_in=0 → oor pulses 1 cycle, err=0. ctr_rst_n=0 gives 0 with oor=0.
- Halt: 4 injected mismatches with ERR_LIMIT=4 → halted=1 and err_cnt=4, frozen under further bad data. clr=1 → IDLE with all counters 0.
- Reset and clear priority: assert rst mid-TRACK → all outputs 0 immediately, without a clock edge. Also, clr=1 and en=1 together → checker stays in IDLE.

Source files
------------

// File: rtl/counter_seq_checker.sv
// Passive checker for the bounded MIN..MAX up/down counter: predicts each next count,
// flags mismatches and tallies verified wraps and out-of-range recoveries.
module counter_seq_checker #(
    parameter int WIDTH     = 8,
    parameter int MIN       = 10,
    parameter int MAX       = 40,
    parameter int ERR_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             ctr_rst_n,
    input  logic             load,
    input  logic             u_d,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH-1:0] exp_count,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic [7:0]       wrap_up_cnt,
    output logic [7:0]       wrap_dn_cnt,
    output logic             oor,
    output logic             halted
);

    localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
    localparam logic [7:0]       LIMIT_V = 8'(ERR_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_NONE    = 2'd0,
        K_WRAP_UP = 2'd1,
        K_WRAP_DN = 2'd2,
        K_OOR     = 2'd3
    } kind_t;

    typedef struct packed {
        kind_t            kind;
        logic [WIDTH-1:0] value;
    } pred_t;

    state_t           state_q, state_d;
    kind_t            kind_q;
    pred_t            pred;
    logic             cmp_en;
    logic             mismatch;
    logic             err_d;
    logic             oor_d;
    logic             wu_inc;
    logic             wd_inc;
    logic [7:0]       err_cnt_inc;

    // Model of the monitored counter's next count, with the kind of step it represents.
    function automatic pred_t predict(
        input logic             rst_n_f,
        input logic             load_f,
        input logic             up_f,
        input logic [WIDTH-1:0] data_f,
        input logic [WIDTH-1:0] c
    );
        pred_t p;
        p.kind  = K_NONE;
        p.value = '0;
        if (!rst_n_f || (c > MAX_V) || (c < MIN_V)) begin
            p.value = '0;
            // a counter held in its own reset is not an out-of-range recovery
            p.kind  = rst_n_f ? K_OOR : K_NONE;
        end else if (load_f) begin
            p.value = data_f;
        end else if (up_f) begin
            if (c >= MAX_V) begin
                p.value = MIN_V;
                p.kind  = K_WRAP_UP;
            end else begin
                p.value = c + 1'b1;
            end
        end else begin
            if (c <= MIN_V) begin
                p.value = MAX_V;
                p.kind  = K_WRAP_DN;
            end else begin
                p.value = c - 1'b1;
            end
        end
        return p;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign pred        = predict(ctr_rst_n, load, u_d, data, count_in);
    assign mismatch    = (count_in != exp_count);
    assign err_cnt_inc = sat_inc(err_cnt);

    always_comb begin
        state_d = state_q;
        cmp_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_TRACK;
            end
            S_TRACK: begin
                cmp_en = 1'b1;
                if (mismatch && (err_cnt_inc == LIMIT_V)) state_d = S_HALT;
                else if (!en)                             state_d = S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (clr) state_d = S_IDLE;
    end

    always_comb begin
        err_d  = cmp_en && mismatch && !clr;
        oor_d  = cmp_en && !mismatch && (kind_q == K_OOR) && !clr;
        wu_inc = cmp_en && !mismatch && (kind_q == K_WRAP_UP) && !clr;
        wd_inc = cmp_en && !mismatch && (kind_q == K_WRAP_DN) && !clr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Comparison results and statistics are registered: flags appear one clock after the sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_count   <= '0;
            kind_q      <= K_NONE;
            err         <= 1'b0;
            oor         <= 1'b0;
            err_cnt     <= '0;
            wrap_up_cnt <= '0;
            wrap_dn_cnt <= '0;
        end else if (clr) begin
            exp_count   <= '0;
            kind_q      <= K_NONE;
            err         <= 1'b0;
            oor         <= 1'b0;
            err_cnt     <= '0;
            wrap_up_cnt <= '0;
            wrap_dn_cnt <= '0;
        end else begin
            err <= err_d;
            oor <= oor_d;
            if (err_d)  err_cnt     <= err_cnt_inc;
            if (wu_inc) wrap_up_cnt <= sat_inc(wrap_up_cnt);
            if (wd_inc) wrap_dn_cnt <= sat_inc(wrap_dn_cnt);
            // a mismatch reloads from the actual count, which also resynchronises
            if (state_d == S_TRACK) begin
                exp_count <= pred.value;
                kind_q    <= pred.kind;
            end
        end
    end

    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_counter_seq_checker.sv
// Bench for counter_seq_checker: table of per-cycle inputs with hand-derived expected outputs.
module tb_counter_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       ctr_rst_n = 1'b1;
    logic       load = 1'b0;
    logic       u_d = 1'b1;
    logic [7:0] data = 8'd0;
    logic [7:0] count_in = 8'd0;
    logic [7:0] exp_count;
    logic       err;
    logic [7:0] err_cnt;
    logic [7:0] wrap_up_cnt;
    logic [7:0] wrap_dn_cnt;
    logic       oor;
    logic       halted;

    int checks = 0;
    int errors = 0;

    counter_seq_checker #(.WIDTH(8), .MIN(10), .MAX(40), .ERR_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .ctr_rst_n(ctr_rst_n),
        .load(load), .u_d(u_d), .data(data), .count_in(count_in),
        .exp_count(exp_count), .err(err), .err_cnt(err_cnt),
        .wrap_up_cnt(wrap_up_cnt), .wrap_dn_cnt(wrap_dn_cnt),
        .oor(oor), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, clr, crn, ld, ud;
        logic [7:0] data, cnt;
        logic [7:0] x_exp;
        logic       x_err;
        logic [7:0] x_ecnt, x_wu, x_wd;
        logic       x_oor, x_halt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];

    task automatic add(input int e, input int c, input int crn, input int ld, input int ud,
                       input int d, input int cnt, input int xe, input int xerr, input int xec,
                       input int xwu, input int xwd, input int xoor, input int xh);
        vec_t v;
        v.en = e[0]; v.clr = c[0]; v.crn = crn[0]; v.ld = ld[0]; v.ud = ud[0];
        v.data = d[7:0]; v.cnt = cnt[7:0];
        v.x_exp = xe[7:0]; v.x_err = xerr[0]; v.x_ecnt = xec[7:0];
        v.x_wu = xwu[7:0]; v.x_wd = xwd[7:0]; v.x_oor = xoor[0]; v.x_halt = xh[0];
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        en = v.en; clr = v.clr; ctr_rst_n = v.crn; load = v.ld; u_d = v.ud;
        data = v.data; count_in = v.cnt;
    endtask

    task automatic check_outputs(input int idx, input vec_t x);
        chk("exp_count", idx, int'(exp_count), int'(x.x_exp));
        chk("err", idx, int'(err), int'(x.x_err));
        chk("err_cnt", idx, int'(err_cnt), int'(x.x_ecnt));
        chk("wrap_up_cnt", idx, int'(wrap_up_cnt), int'(x.x_wu));
        chk("wrap_dn_cnt", idx, int'(wrap_dn_cnt), int'(x.x_wd));
        chk("oor", idx, int'(oor), int'(x.x_oor));
        chk("halted", idx, int'(halted), int'(x.x_halt));
    endtask

    // Drive one vector, queue its expectation, and compare once the edge has taken effect.
    task automatic apply(input int idx, input vec_t v);
        vec_t x;
        drive(v);
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", idx, 0, 1);
        end else begin
            x = sb_q.pop_front();
            check_outputs(idx, x);
        end
    endtask

    initial begin
        vec_t v;
        //  en clr crn ld ud data cnt | exp err ecnt wu wd oor halt
        // up run through the MAX->MIN wrap
        add(1, 0, 1, 0, 1,  0, 37,   38, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1,  0, 38,   39, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1,  0, 39,   40, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1,  0, 40,   10, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1,  0, 10,   11, 0, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 1,  0, 11,   12, 0, 0, 1, 0, 0, 0);
        // down run through the MIN->MAX wrap
        add(1, 0, 1, 0, 0,  0, 12,   11, 0, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0,  0, 11,   10, 0, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0,  0, 10,   40, 0, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0,  0, 40,   39, 0, 0, 1, 1, 0, 0);
        // loads, one injected mismatch and resync
        add(1, 0, 1, 1, 0, 30, 39,   30, 0, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 0, 25, 30,   25, 0, 0, 1, 1, 0, 0);
        add(1, 0, 1, 0, 1,  0, 25,   26, 0, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 1, 25, 26,   25, 0, 0, 1, 1, 0, 0);
        add(1, 0, 1, 0, 1,  0, 26,   27, 1, 1, 1, 1, 0, 0);
        add(1, 0, 1, 0, 1,  0, 27,   28, 0, 1, 1, 1, 0, 0);
        add(1, 0, 1, 0, 1,  0, 28,   29, 0, 1, 1, 1, 0, 0);
        // out-of-range 50 forced to 0, then counter held in its own reset
        add(1, 0, 1, 1, 1, 50, 29,   50, 0, 1, 1, 1, 0, 0);
        add(1, 0, 1, 0, 1,  0, 50,    0, 0, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 1,  0,  0,    0, 0, 1, 1, 1, 1, 0);
        add(1, 0, 0, 0, 1,  0,  0,    0, 0, 1, 1, 1, 0, 0);
        // clear with en high stays in IDLE
        add(1, 1, 1, 0, 1,  0, 20,    0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 1,  0, 20,    0, 0, 0, 0, 0, 0, 0);
        // four mismatches (one on a predicted wrap) reach HALT, then frozen
        add(1, 0, 1, 0, 1,  0, 20,   21, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1,  0, 30,   31, 1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1,  0, 40,   10, 1, 2, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1,  0, 11,   12, 1, 3, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1,  0, 20,   12, 1, 4, 0, 0, 0, 1);
        add(1, 0, 1, 0, 1,  0, 33,   12, 0, 4, 0, 0, 0, 1);
        add(1, 0, 1, 0, 1,  0, 13,   12, 0, 4, 0, 0, 0, 1);
        add(1, 1, 1, 0, 1,  0, 13,    0, 0, 0, 0, 0, 0, 0);
        // en falling: last comparison still made, then no comparison
        add(1, 0, 1, 0, 1,  0, 15,   16, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1,  0, 99,   16, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1,  0,  5,   16, 0, 1, 0, 0, 0, 0);

        // reset state, checked before any clock edge releases it
        #2 rst = 1'b0;
        #1;
        chk("reset_exp_count", 0, int'(exp_count), 0);
        chk("reset_err_cnt", 0, int'(err_cnt), 0);
        chk("reset_halted", 0, int'(halted), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset_exp", 0, int'(exp_count), 0);
        chk("idle_after_reset_err", 0, int'(err), 0);

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // wrap_up_cnt saturation: 260 verified MAX->MIN wraps
        v = tbl[0];
        v.en = 1; v.clr = 1; v.crn = 1; v.ld = 0; v.ud = 1; v.data = 0; v.cnt = 20;
        drive(v);
        @(posedge clk); #1;
        v.clr = 0; v.ld = 1; v.data = 40; v.cnt = 10;
        drive(v);
        @(posedge clk); #1;
        for (int k = 0; k < 260; k++) begin
            v.ld = 0; v.cnt = 40;
            drive(v);
            @(posedge clk); #1;
            v.ld = 1; v.data = 40; v.cnt = 10;
            drive(v);
            @(posedge clk); #1;
        end
        chk("wrap_up_saturate", 0, int'(wrap_up_cnt), 255);
        chk("wrap_up_sat_err_cnt", 0, int'(err_cnt), 0);

        // asynchronous reset in the middle of TRACK with a pending error pulse
        v.en = 1; v.clr = 1; v.ld = 0; v.cnt = 20;
        drive(v);
        @(posedge clk); #1;
        v.clr = 0;
        drive(v);
        @(posedge clk); #1;
        chk("pre_rst_exp", 0, int'(exp_count), 21);
        v.cnt = 22;
        drive(v);
        @(posedge clk); #1;
        chk("pre_rst_err", 0, int'(err), 1);
        chk("pre_rst_err_cnt", 0, int'(err_cnt), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_err", 0, int'(err), 0);
        chk("async_rst_err_cnt", 0, int'(err_cnt), 0);
        chk("async_rst_exp", 0, int'(exp_count), 0);
        chk("async_rst_wrap_up", 0, int'(wrap_up_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        // back through IDLE: first edge only loads a prediction, no comparison on bad data
        v.cnt = 30;
        drive(v);
        @(posedge clk); #1;
        chk("resume_idle_err", 0, int'(err), 0);
        chk("resume_idle_exp", 0, int'(exp_count), 31);
        v.cnt = 31;
        drive(v);
        @(posedge clk); #1;
        chk("resume_track_err", 0, int'(err), 0);
        chk("resume_track_exp", 0, int'(exp_count), 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
